// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO bridge: register map, STATUS layout and port FSM states.
// Optional interrupt support in the bridge is enabled with `define UART_MMIO_BRIDGE_IRQ_EN.
package uart_mmio_pkg;
    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int STAT_RX_NONEMPTY = 0;
    localparam int STAT_TX_FULL     = 1;
    localparam int STAT_TX_EMPTY    = 2;
    localparam int STAT_TX_OVF      = 3;
    localparam int STAT_RX_COUNT    = 8;
    localparam int STAT_TX_FREE     = 16;
    localparam int STAT_IE          = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TX   = 2'd1,
        RX   = 2'd2
    } port_state_e;

    // Counts wider than an 8-bit STATUS field saturate instead of wrapping.
    function automatic logic [7:0] sat8(input logic [31:0] v);
        logic [7:0] r;
        if (v > 32'd255) begin
            r = 8'hFF;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction
endpackage

// File: rtl/uart_mmio_bridge_fifo.sv
// Byte FIFO used for both bridge directions; a pop in the same cycle as a push frees the slot first.
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign do_pop_s  = pop & (count_r != {(AW + 1){1'b0}});
    assign do_push_s = push & ((count_r != FULL_CNT) | do_pop_s);

    // Storage array; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == {(AW + 1){1'b0}});
    assign count = count_r;
endmodule

// File: rtl/uart_mmio_bridge.sv
// picorv32 native-bus peripheral that buffers usb_uart traffic in TX/RX FIFOs behind DATA/STATUS registers.
// Define UART_MMIO_BRIDGE_IRQ_EN to add the irq output and the STATUS[25:24] interrupt-enable field.
module uart_mmio_bridge
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0008,
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        uart_we,
    output logic        uart_re,
    output logic [7:0]  uart_di,
    input  logic [7:0]  uart_do,
    input  logic        uart_wait
`ifdef UART_MMIO_BRIDGE_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    logic              hit_s, is_status_s, is_write_s;
    logic              cpu_tx_push_s, cpu_rx_pop_s, ovf_set_s, ovf_clr_s;
    logic              port_tx_pop_s, port_rx_push_s;
    logic [7:0]        tx_dout_s, rx_dout_s;
    logic              tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic [TX_CW-1:0]  tx_count_s;
    logic [RX_CW-1:0]  rx_count_s;
    logic [31:0]       status_s, rdata_nx_s;
    logic              ready_r, ovf_r;
    logic [31:0]       rdata_r;
    port_state_e       state_r, state_nx_s;
    logic              last_rx_r, last_rx_nx_s;
    logic              we_r, we_nx_s, re_r, re_nx_s;
    logic [7:0]        di_r, di_nx_s;
    logic              unused_s;

    assign unused_s = ^{mem_addr[1:0], mem_wdata[31:8]};

    // A hit is blocked while the previous completion pulse is still out.
    assign hit_s         = mem_valid & (mem_addr[31:3] == BASE_ADDR[31:3]) & ~ready_r;
    assign is_status_s   = (mem_addr[2] == REG_STATUS[2]);
    assign is_write_s    = |mem_wstrb;
    assign cpu_tx_push_s = hit_s & ~is_status_s & is_write_s & mem_wstrb[0];
    assign cpu_rx_pop_s  = hit_s & ~is_status_s & ~is_write_s & ~rx_empty_s;
    assign ovf_set_s     = cpu_tx_push_s & tx_full_s & ~port_tx_pop_s;
    assign ovf_clr_s     = hit_s & is_status_s & is_write_s & mem_wdata[STAT_TX_OVF];

    uart_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (cpu_tx_push_s),
        .din    (mem_wdata[7:0]),
        .pop    (port_tx_pop_s),
        .dout   (tx_dout_s),
        .full   (tx_full_s),
        .empty  (tx_empty_s),
        .count  (tx_count_s)
    );

    uart_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (port_rx_push_s),
        .din    (uart_do),
        .pop    (cpu_rx_pop_s),
        .dout   (rx_dout_s),
        .full   (rx_full_s),
        .empty  (rx_empty_s),
        .count  (rx_count_s)
    );

`ifdef UART_MMIO_BRIDGE_IRQ_EN
    logic [1:0] ie_r;
    logic       irq_r;

    // Interrupt enables and the registered interrupt line.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ie_r  <= 2'b00;
            irq_r <= 1'b0;
        end else begin
            if (hit_s && is_status_s && is_write_s) begin
                ie_r <= mem_wdata[STAT_IE +: 2];
            end else begin
                ie_r <= ie_r;
            end
            irq_r <= (~rx_empty_s & ie_r[0]) | (tx_empty_s & ie_r[1]);
        end
    end

    assign irq = irq_r;
`endif

    // STATUS word assembled from live FIFO state.
    always_comb begin
        status_s = 32'h0000_0000;
        status_s[STAT_RX_NONEMPTY]   = ~rx_empty_s;
        status_s[STAT_TX_FULL]       = tx_full_s;
        status_s[STAT_TX_EMPTY]      = tx_empty_s;
        status_s[STAT_TX_OVF]        = ovf_r;
        status_s[STAT_RX_COUNT +: 8] = sat8(32'(rx_count_s));
        status_s[STAT_TX_FREE +: 8]  = sat8(32'(TX_DEPTH) - 32'(tx_count_s));
`ifdef UART_MMIO_BRIDGE_IRQ_EN
        status_s[STAT_IE +: 2]       = ie_r;
`endif
    end

    // Read data for the completion pulse; bit 8 flags a valid received byte.
    always_comb begin
        rdata_nx_s = 32'h0000_0000;
        if (hit_s && !is_write_s) begin
            if (is_status_s) begin
                rdata_nx_s = status_s;
            end else if (!rx_empty_s) begin
                rdata_nx_s = {23'h000000, 1'b1, rx_dout_s};
            end else begin
                rdata_nx_s = 32'h0000_0000;
            end
        end else begin
            rdata_nx_s = 32'h0000_0000;
        end
    end

    // Bus response registers and the sticky overflow flag (set beats clear).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_r <= 1'b0;
            rdata_r <= 32'h0000_0000;
            ovf_r   <= 1'b0;
        end else begin
            ready_r <= hit_s;
            rdata_r <= rdata_nx_s;
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr_s) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    // Port FSM: alternates TX and RX service; a stalled RX poll yields to pending TX data.
    always_comb begin
        state_nx_s     = state_r;
        last_rx_nx_s   = last_rx_r;
        we_nx_s        = 1'b0;
        re_nx_s        = 1'b0;
        di_nx_s        = di_r;
        port_tx_pop_s  = 1'b0;
        port_rx_push_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!tx_empty_s && (last_rx_r || rx_full_s)) begin
                    state_nx_s = TX;
                    we_nx_s    = 1'b1;
                    di_nx_s    = tx_dout_s;
                end else if (!rx_full_s) begin
                    state_nx_s = RX;
                    re_nx_s    = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            TX: begin
                if (uart_wait) begin
                    we_nx_s = 1'b1;
                end else begin
                    port_tx_pop_s = 1'b1;
                    last_rx_nx_s  = 1'b0;
                    state_nx_s    = IDLE;
                end
            end
            RX: begin
                if (!uart_wait) begin
                    port_rx_push_s = 1'b1;
                    last_rx_nx_s   = 1'b1;
                    state_nx_s     = IDLE;
                end else if (!tx_empty_s) begin
                    last_rx_nx_s = 1'b1;
                    state_nx_s   = IDLE;
                end else begin
                    re_nx_s = 1'b1;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Port FSM state and registered usb_uart strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= IDLE;
            last_rx_r <= 1'b1;
            we_r      <= 1'b0;
            re_r      <= 1'b0;
            di_r      <= 8'h00;
        end else begin
            state_r   <= state_nx_s;
            last_rx_r <= last_rx_nx_s;
            we_r      <= we_nx_s;
            re_r      <= re_nx_s;
            di_r      <= di_nx_s;
        end
    end

    assign mem_ready = ready_r;
    assign mem_rdata = rdata_r;
    assign uart_we   = we_r;
    assign uart_re   = re_r;
    assign uart_di   = di_r;
endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Self-checking bench for uart_mmio_bridge: queue-based reference model checked every cycle, plus directed pins.
module tb_uart_mmio_bridge;
    localparam logic [31:0] BASE   = 32'h0200_0008;
    localparam logic [31:0] DATA_A = BASE;
    localparam logic [31:0] STAT_A = BASE + 32'd4;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        uart_we, uart_re;
    logic [7:0]  uart_di;
    logic [7:0]  uart_do = 8'h00;
    logic        uart_wait = 1'b1;

    uart_mmio_bridge #(.BASE_ADDR(BASE), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .uart_we   (uart_we),
        .uart_re   (uart_re),
        .uart_di   (uart_di),
        .uart_do   (uart_do),
        .uart_wait (uart_wait)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as queues, plus sticky flag and service order.
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    logic [7:0]  tx_log[$];
    bit          m_ovf = 1'b0;
    bit          m_last_rx = 1'b1;
    bit          exp_ready = 1'b0, exp_we = 1'b0, exp_re = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    bit          m_hit, m_st, m_wr, m_txd, m_rxd, n_we, n_re;
    logic [31:0] n_rdata;

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s        = 32'h0;
        s[0]     = (rxq.size() != 0);
        s[1]     = (txq.size() == 16);
        s[2]     = (txq.size() == 0);
        s[3]     = m_ovf;
        s[15:8]  = 8'(rxq.size());
        s[23:16] = 8'(16 - txq.size());
        return s;
    endfunction

    // Compare process: checks outputs, then advances the model by this cycle's events.
    always @(negedge clk) begin
        if (!resetn) begin
            txq.delete();
            rxq.delete();
            m_ovf = 1'b0;
            m_last_rx = 1'b1;
            exp_ready = 1'b0;
            exp_we = 1'b0;
            exp_re = 1'b0;
            check("reset_outputs", {29'b0, mem_ready, uart_we, uart_re}, 32'd0);
        end else begin
            check("mem_ready", 32'(mem_ready), 32'(exp_ready));
            if (exp_ready) check("mem_rdata", mem_rdata, exp_rdata);
            check("uart_we", 32'(uart_we), 32'(exp_we));
            check("uart_re", 32'(uart_re), 32'(exp_re));
            if (exp_we && txq.size() != 0) check("uart_di", 32'(uart_di), 32'(txq[0]));

            m_hit = mem_valid && (mem_addr[31:3] == BASE[31:3]) && !exp_ready;
            m_st  = mem_addr[2];
            m_wr  = (mem_wstrb != 4'h0);
            m_txd = exp_we && !uart_wait;
            m_rxd = exp_re && !uart_wait;

            n_rdata = 32'h0;
            if (m_hit && !m_wr) begin
                if (m_st) n_rdata = model_status();
                else if (rxq.size() != 0) n_rdata = {23'h0, 1'b1, rxq[0]};
            end

            n_we = 1'b0;
            n_re = 1'b0;
            if (exp_we) begin
                n_we = uart_wait;
            end else if (exp_re) begin
                n_re = uart_wait && (txq.size() == 0);
                if (!n_re) m_last_rx = 1'b1;
            end else if (txq.size() != 0 && (m_last_rx || rxq.size() == 16)) begin
                n_we = 1'b1;
            end else if (rxq.size() < 16) begin
                n_re = 1'b1;
            end

            if (m_txd) begin
                m_last_rx = 1'b0;
                tx_log.push_back(uart_di);
                void'(txq.pop_front());
            end
            if (m_hit && !m_wr && !m_st && rxq.size() != 0) void'(rxq.pop_front());
            if (m_rxd) rxq.push_back(uart_do);
            if (m_hit && m_wr && !m_st && mem_wstrb[0]) begin
                if (txq.size() < 16) txq.push_back(mem_wdata[7:0]);
                else m_ovf = 1'b1;
            end
            if (m_hit && m_wr && m_st && mem_wdata[3]) m_ovf = 1'b0;

            exp_ready = m_hit;
            exp_rdata = n_rdata;
            exp_we    = n_we;
            exp_re    = n_re;
        end
    end

    task automatic bus_op(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata);
        bit acked;
        acked = 1'b0;
        rdata = 32'h0;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                rdata  = mem_rdata;
                acked  = 1'b1;
            end
        end
        mem_valid = 1'b0;
        check("bus_ack", 32'(acked), 32'd1);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        bus_op(addr, wdata, 4'hF, dummy);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] rdata);
        bus_op(addr, 32'h0, 4'h0, rdata);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain_rx();
        logic [31:0] r;
        r = 32'h1;
        for (int i = 0; i < 20 && r != 32'h0; i++) rd(DATA_A, r);
        check("rx_drained", r, 32'h0);
    endtask

    logic [31:0] r;
    bit          rand_uart = 1'b0;
    int          wait_pct = 50;
    int          pcts[4] = '{10, 50, 90, 30};

    initial begin
        #1 resetn = 1'b0;
        idle(3);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_strobes", {30'b0, uart_we, uart_re}, 32'd0);
        check("rst_di", 32'(uart_di), 32'd0);
        resetn = 1'b1;
        idle(1);

        rd(STAT_A, r);
        check("status_after_reset", r, 32'h0010_0004);

        // Two bytes out with a ready usb_uart.
        uart_do = 8'hA5;
        uart_wait = 1'b0;
        tx_log.delete();
        wr(DATA_A, 32'h41);
        wr(DATA_A, 32'h42);
        idle(10);
        uart_wait = 1'b1;
        check("t2_tx_count", 32'(tx_log.size()), 32'd2);
        if (tx_log.size() == 2) begin
            check("t2_byte0", 32'(tx_log[0]), 32'h41);
            check("t2_byte1", 32'(tx_log[1]), 32'h42);
        end
        rd(STAT_A, r);
        check("t2_tx_empty", 32'(r[2]), 32'd1);
        rd(DATA_A, r);
        check("t2_first_rx", r, 32'h0000_01A5);
        drain_rx();

        // Overflow with a stalled usb_uart, then clear.
        for (int i = 0; i < 17; i++) wr(DATA_A, 32'h60 + 32'(i));
        rd(STAT_A, r);
        check("t3_full_ovf", r, 32'h0000_000A);
        wr(STAT_A, 32'h8);
        rd(STAT_A, r);
        check("t3_ovf_cleared", r, 32'h0000_0002);
        tx_log.delete();
        uart_do = 8'h77;
        uart_wait = 1'b0;
        idle(100);
        uart_wait = 1'b1;
        check("t3_tx_count", 32'(tx_log.size()), 32'd16);
        for (int i = 0; i < 16 && i < tx_log.size(); i++) check("t3_tx_byte", 32'(tx_log[i]), 32'h60 + 32'(i));
        drain_rx();

        // Single received byte.
        uart_do = 8'h55;
        for (int i = 0; i < 5 && !uart_re; i++) idle(1);
        check("t4_re_seen", 32'(uart_re), 32'd1);
        uart_wait = 1'b0;
        idle(1);
        uart_wait = 1'b1;
        rd(STAT_A, r);
        check("t4_status", r, 32'h0010_0105);
        rd(DATA_A, r);
        check("t4_data", r, 32'h0000_0155);
        rd(DATA_A, r);
        check("t4_data_empty", r, 32'h0);

        // Pending RX poll yields to a new TX byte.
        idle(2);
        check("t5_re_pending", 32'(uart_re), 32'd1);
        wr(DATA_A, 32'h33);
        idle(3);
        check("t5_re_dropped", 32'(uart_re), 32'd0);
        check("t5_we", 32'(uart_we), 32'd1);
        check("t5_di", 32'(uart_di), 32'h33);
        rd(STAT_A, r);
        check("t5_status", r, 32'h000F_0000);

        // Asynchronous reset while a TX strobe is stalled.
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 check("t6_we_async", 32'(uart_we), 32'd0);
        idle(2);
        resetn = 1'b1;
        idle(1);
        rd(STAT_A, r);
        check("t6_status", r, 32'h0010_0004);

        // Randomised traffic checked by the model.
        rand_uart = 1'b1;
        fork
            begin
                while (rand_uart) begin
                    @(posedge clk);
                    #1;
                    uart_wait = ($urandom_range(0, 99) < wait_pct);
                    uart_do   = 8'($urandom);
                end
            end
            begin
                for (int ph = 0; ph < 4; ph++) begin
                    wait_pct = pcts[ph];
                    for (int k = 0; k < 120; k++) begin
                        case ($urandom_range(0, 9))
                            0, 1, 2, 3: bus_op(DATA_A + 32'($urandom_range(0, 3)), $urandom,
                                               4'($urandom_range(1, 15)), r);
                            4, 5:       rd(DATA_A + 32'($urandom_range(0, 3)), r);
                            6:          rd(STAT_A + 32'($urandom_range(0, 3)), r);
                            7:          wr(STAT_A, $urandom);
                            8: begin
                                mem_valid = 1'b1;
                                mem_addr  = BASE ^ 32'h0000_0100;
                                mem_wstrb = 4'($urandom_range(0, 15));
                                idle(3);
                                mem_valid = 1'b0;
                            end
                            default:    idle($urandom_range(1, 6));
                        endcase
                    end
                end
                rand_uart = 1'b0;
            end
        join
        uart_wait = 1'b1;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_mmio_bridge.md
Name: uart_mmio_bridge

Overview:
- picorv32 native-bus responder (memory-mapped peripheral) in front of the usb_uart byte port (uart_we/uart_re/uart_di/uart_do/uart_wait).
- Replaces the CPU's direct, blocking access to usb_uart with TX/RX byte FIFOs and a status register, so firmware polls instead of stalling the bus.
- The bridge acts as the initiator toward usb_uart: it drains the TX FIFO and prefetches received bytes autonomously.

Parameters:
- BASE_ADDR, 32'h0200_0008, byte address of the DATA register; STATUS is at BASE_ADDR+4.
- TX_DEPTH, 16, TX FIFO depth in bytes; power of two, minimum 2.
- RX_DEPTH, 16, RX FIFO depth in bytes; power of two, minimum 2.

Ports:
- clk  in  1  system clock; usb_uart port is synchronous to it.
- resetn  in  1  asynchronous active-low reset.
- mem_valid  in  1  CPU bus request.
- mem_addr  in  32  CPU byte address.
- mem_wdata  in  32  write data; byte 0 is used.
- mem_wstrb  in  4  write strobes; all zero means read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- uart_we  out  1  write strobe to usb_uart.
- uart_re  out  1  read strobe to usb_uart.
- uart_di  out  8  byte to usb_uart.
- uart_do  in  8  byte from usb_uart.
- uart_wait  in  1  usb_uart not ready; a transfer completes on a cycle with (we|re)=1 and uart_wait=0.

Behaviour:
- Reset values:
  - mem_ready=0, mem_rdata=0.
  - uart_we=0, uart_re=0, uart_di=0.
  - FIFOs empty, FSM IDLE.
- Bus selection:
  - hit = mem_valid & (mem_addr[31:3] == BASE_ADDR[31:3]) & !mem_ready.
  - mem_ready is registered: it pulses the cycle after the hit.
  - At most one transaction is accepted per pulse; a hit is never accepted while mem_ready=1.
- DATA write (mem_wstrb[0]=1):
  - Pushes mem_wdata[7:0] into the TX FIFO.
  - If the TX FIFO is full, the byte is dropped and sticky tx_ovf is set.
  - mem_ready always pulses, so the bus never stalls.
- DATA read:
  - If the RX FIFO is non-empty, pops one byte; mem_rdata={23'b0, 1'b1, byte}, i.e. bit 8 = valid.
  - If empty, mem_rdata=0 and no pop.
- STATUS read:
  - bit0 rx_nonempty, bit1 tx_full, bit2 tx_empty, bit3 tx_ovf.
  - bits[15:8] rx count, bits[23:16] tx free count.
- STATUS write with wdata[3]=1 clears tx_ovf.
- Sticky flag collision: a set in the same cycle as a clear wins (flag stays 1).
- Simultaneous push and pop on the same FIFO in one cycle:
  - Both occur; count is unchanged.
  - Legal even when full (the pop frees the slot first).
- Port FSM:
  - IDLE:
    - If the TX FIFO is non-empty and (last_served==RX or the RX FIFO is full), go to TX; drive uart_di=head and uart_we=1.
    - Else if the RX FIFO has at least one free entry, go to RX; uart_re=1.
    - Otherwise stay in IDLE.
  - TX:
    - Hold uart_we and uart_di stable while uart_wait=1.
    - On uart_wait=0: pop the TX FIFO, set last_served=TX, drop uart_we next cycle, return to IDLE.
  - RX:
    - On uart_wait=0: push uart_do into the RX FIFO, set last_served=RX, drop uart_re, go to IDLE.
    - If uart_wait=1 and the TX FIFO is non-empty: abort by dropping uart_re, go to IDLE, set last_served=RX. Abort consumes no byte.
- uart_we and uart_re are never high in the same cycle, and each strobe is always followed by at least one IDLE cycle.
- Asynchronous reset mid-transfer: strobes drop immediately and FIFO contents are discarded.

Optional Feature:
- Macro UART_MMIO_BRIDGE_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, reset 0), registered: irq = (rx_nonempty & ie[0]) | (tx_empty & ie[1]).
  - ie is written through STATUS wdata[25:24] and read back on STATUS bits[25:24].
- Undefined:
  - No irq port and no ie register.
  - STATUS bits[25:24] read 0 and writes to them are ignored.

Decomposition:
- Package uart_mmio_pkg:
  - Register offsets DATA=0, STATUS=4.
  - STATUS bit indices.
  - FSM state enum {IDLE, TX, RX}.
- One sub-module, uart_byte_fifo (parameter DEPTH):
  - Ports: clk, resetn, push, din, pop, dout, full, empty, count.
  - Instantiated twice, for TX and RX.

Test Plan:
- Reset, then read STATUS -> rdata=32'h0010_0004 (tx free=16, tx_empty=1); uart_we=uart_re=0.
- Write 0x41, 0x42 to DATA with uart_wait=0 -> uart_di=0x41 then 0x42, each with one uart_we pulse; tx_empty returns to 1.
- Hold uart_wait=1 and write 17 bytes -> 16 queued, tx_full=1, tx_ovf=1; STATUS write of 0x8 clears tx_ovf.
- usb_uart supplies 0x55 -> RX FIFO count=1; DATA read returns 32'h0000_0155; next DATA read returns 0.
- RX strobe pending with uart_wait=1, then CPU writes 0x33 -> uart_re drops, uart_we asserts with uart_di=0x33, no RX byte consumed.
- Assert resetn=0 during uart_we with uart_wait=1 -> uart_we=0 in the same cycle; after release, STATUS shows both FIFOs empty.
